// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/D memory arbiter.
// States and owner ids used by mem_arbiter and mem_arb_pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin; default is fixed D > IF.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  owner_e last_owner,
  output logic   grant_if,
  output logic   grant_d
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (if_req && d_req) begin
      // Port that did not win last time goes first
      if (last_owner == OWN_D) grant_if = 1'b1;
      else                     grant_d  = 1'b1;
    end else begin
      grant_if = if_req;
      grant_d  = d_req;
    end
  end
`else
  logic unused_last;
  assign unused_last = last_owner;

  assign grant_d  = d_req;
  assign grant_if = if_req & ~d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: IF and D share one bus, 3 cycles/access.
// Define MEM_ARB_RR_EN for round-robin instead of fixed D > IF.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d;
  logic              if_rv_q, if_rv_d;
  logic              d_rv_q, d_rv_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] d_rd_q, d_rd_d;
  logic              grant_if, grant_d;
  logic              idle;
  owner_e            last_owner;

  assign idle = (state_q == ST_IDLE);

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .grant_if   (grant_if),
    .grant_d    (grant_d)
  );

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= OWN_IF;
    end else if (idle && grant_d) begin
      last_q <= OWN_D;
    end else if (idle && grant_if) begin
      last_q <= OWN_IF;
    end
  end

  assign last_owner = last_q;
`else
  assign last_owner = OWN_IF;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d = ST_ACCESS;
          owner_d = OWN_D;
          addr_d  = d_addr;
          wd_d    = d_wd;
          we_d    = d_we;
        end else if (grant_if) begin
          state_d = ST_ACCESS;
          owner_d = OWN_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
        end
      end
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Responses register on the CAPTURE edge; stores leave rdata alone
  always_comb begin
    if_rv_d = (state_q == ST_CAPTURE) && (owner_q == OWN_IF);
    d_rv_d  = (state_q == ST_CAPTURE) && (owner_q == OWN_D);
    if_rd_d = if_rv_d ? mem_rd : if_rd_q;
    d_rd_d  = (d_rv_d && !we_q) ? mem_rd : d_rd_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      if_rv_q <= 1'b0;
      d_rv_q  <= 1'b0;
      if_rd_q <= '0;
      d_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      if_rv_q <= if_rv_d;
      d_rv_q  <= d_rv_d;
      if_rd_q <= if_rd_d;
      d_rd_q  <= d_rd_d;
    end
  end

  // Ready is gated by rstn so it reads 0 while reset is held
  assign if_ready  = rstn && idle && grant_if;
  assign d_ready   = rstn && idle && grant_d;
  assign if_rvalid = if_rv_q;
  assign d_rvalid  = d_rv_q;
  assign if_rdata  = if_rd_q;
  assign d_rdata   = d_rd_q;
  assign mem_we    = (state_q == ST_ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wd    = wd_q;
  assign busy      = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Build with +define+MEM_ARB_RR_EN to test round-robin.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wd, d_rdata;
  logic        mem_we, busy;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  int          pass_cnt = 0;
  int          total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wd      (d_wd),
    .d_ready   (d_ready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .busy      (busy)
  );

  // Inputs change 1ns after the edge; checks run 4ns after the edge
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 32'h55; d_addr = 32'h66; d_we = 1'b1;
    d_wd = 32'h77; mem_rd = '0;
    #3;
    total++; if (if_ready !== 1'b0 || d_ready !== 1'b0) $display("FAIL rst_ready got if=%b d=%b want 0 0", if_ready, d_ready); else pass_cnt++;
    total++; if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_busy_we got busy=%b we=%b want 0 0", busy, mem_we); else pass_cnt++;
    total++; if (mem_addr !== 32'h0 || mem_wd !== 32'h0) $display("FAIL rst_bus got addr=%h wd=%h want 0 0", mem_addr, mem_wd); else pass_cnt++;
    total++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL rst_rdata got if=%h d=%h want 0 0", if_rdata, d_rdata); else pass_cnt++;
    total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL rst_rvalid got if=%b d=%b want 0 0", if_rvalid, d_rvalid); else pass_cnt++;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    next(); next();
    rstn = 1'b1;
    next();
  endtask

  task automatic test_fetch();
    next(); if_req = 1'b1; if_addr = 32'h0001_0004; d_we = 1'b1; #3;
    total++; if (if_ready !== 1'b1 || d_ready !== 1'b0) $display("FAIL fetch_c0_ready got if=%b d=%b want 1 0", if_ready, d_ready); else pass_cnt++;
    next(); if_req = 1'b0; if_addr = '0; #3;
    total++; if (busy !== 1'b1 || if_ready !== 1'b0) $display("FAIL fetch_c1_busy got busy=%b rdy=%b want 1 0", busy, if_ready); else pass_cnt++;
    total++; if (mem_addr !== 32'h0001_0004 || mem_we !== 1'b0) $display("FAIL fetch_c1_bus got addr=%h we=%b want 00010004 0", mem_addr, mem_we); else pass_cnt++;
    next(); mem_rd = 32'h0000_0013; #3;
    total++; if (mem_addr !== 32'h0001_0004 || mem_we !== 1'b0) $display("FAIL fetch_c2_bus got addr=%h we=%b want 00010004 0", mem_addr, mem_we); else pass_cnt++;
    next(); mem_rd = '0; d_we = 1'b0; #3;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h13) $display("FAIL fetch_c3_resp got v=%b d=%h want 1 00000013", if_rvalid, if_rdata); else pass_cnt++;
    total++; if (d_rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL fetch_c3_idle got dv=%b busy=%b want 0 0", d_rvalid, busy); else pass_cnt++;
    next(); #3;
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h13) $display("FAIL fetch_c4_pulse got v=%b d=%h want 0 00000013", if_rvalid, if_rdata); else pass_cnt++;
  endtask

  task automatic test_store();
    next(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0010_0008; d_wd = 32'hDEAD_BEEF; #3;
    total++; if (d_ready !== 1'b1 || mem_we !== 1'b0) $display("FAIL st_c0 got rdy=%b we=%b want 1 0", d_ready, mem_we); else pass_cnt++;
    next(); d_req = 1'b0; d_we = 1'b0; d_wd = '0; d_addr = '0; #3;
    total++; if (mem_we !== 1'b1) $display("FAIL st_c1_we got %b want 1", mem_we); else pass_cnt++;
    total++; if (mem_addr !== 32'h0010_0008 || mem_wd !== 32'hDEAD_BEEF) $display("FAIL st_c1_bus got addr=%h wd=%h want 00100008 deadbeef", mem_addr, mem_wd); else pass_cnt++;
    next(); mem_rd = 32'hBAD0_BAD0; #3;
    total++; if (mem_we !== 1'b0 || mem_addr !== 32'h0010_0008) $display("FAIL st_c2 got we=%b addr=%h want 0 00100008", mem_we, mem_addr); else pass_cnt++;
    next(); mem_rd = '0; #3;
    total++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) $display("FAIL st_c3_valid got dv=%b iv=%b want 1 0", d_rvalid, if_rvalid); else pass_cnt++;
    total++; if (d_rdata !== 32'h0 || if_rdata !== 32'h13) $display("FAIL st_c3_rdata got d=%h if=%h want 0 00000013", d_rdata, if_rdata); else pass_cnt++;
    total++; if (mem_wd !== 32'hDEAD_BEEF) $display("FAIL st_c3_wd_hold got %h want deadbeef", mem_wd); else pass_cnt++;
    next(); #3;
    total++; if (d_rvalid !== 1'b0) $display("FAIL st_c4_pulse got %b want 0", d_rvalid); else pass_cnt++;
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_collision();
    next(); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0010_0000; if_addr = 32'h0001_0008; #3;
    for (int t = 0; t < 4; t++) begin
      if (t != 0) begin
        next(); next(); next(); #3;
      end
      total++;
      if ((t % 2) == 0) begin
        if (d_ready !== 1'b1 || if_ready !== 1'b0) $display("FAIL rr_grant%0d got d=%b if=%b want 1 0", t, d_ready, if_ready); else pass_cnt++;
      end else begin
        if (if_ready !== 1'b1 || d_ready !== 1'b0) $display("FAIL rr_grant%0d got if=%b d=%b want 1 0", t, if_ready, d_ready); else pass_cnt++;
      end
    end
    next(); if_req = 1'b0; d_req = 1'b0;
    next(); next(); next();
  endtask
`else
  task automatic test_collision();
    next(); if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0010_0000; if_addr = 32'h0001_0008; #3;
    total++; if (d_ready !== 1'b1 || if_ready !== 1'b0) $display("FAIL col_c0 got d=%b if=%b want 1 0", d_ready, if_ready); else pass_cnt++;
    next(); #3;
    total++; if (d_ready !== 1'b0 || if_ready !== 1'b0) $display("FAIL col_c1 got d=%b if=%b want 0 0", d_ready, if_ready); else pass_cnt++;
    next(); mem_rd = 32'h1111_2222; #3;
    total++; if (mem_addr !== 32'h0010_0000) $display("FAIL col_c2_addr got %h want 00100000", mem_addr); else pass_cnt++;
    next(); d_req = 1'b0; mem_rd = '0; #3;
    total++; if (if_ready !== 1'b1 || d_ready !== 1'b0) $display("FAIL col_c3 got if=%b d=%b want 1 0", if_ready, d_ready); else pass_cnt++;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1111_2222) $display("FAIL col_c3_resp got v=%b d=%h want 1 11112222", d_rvalid, d_rdata); else pass_cnt++;
    next(); if_req = 1'b0; #3;
    total++; if (mem_addr !== 32'h0001_0008 || mem_we !== 1'b0) $display("FAIL col_c4_bus got addr=%h we=%b want 00010008 0", mem_addr, mem_we); else pass_cnt++;
    next(); mem_rd = 32'h0000_0033;
    next(); mem_rd = '0; #3;
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h33) $display("FAIL col_c6_resp got v=%b d=%h want 1 00000033", if_rvalid, if_rdata); else pass_cnt++;
  endtask
`endif

  task automatic test_back_to_back();
    next(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0010_0010; #3;
    total++; if (d_ready !== 1'b1) $display("FAIL b2b_c0 got %b want 1", d_ready); else pass_cnt++;
    next();
    next(); mem_rd = 32'hA5A5_0001;
    next(); mem_rd = '0; d_addr = 32'h0010_0014; #3;
    total++; if (d_rvalid !== 1'b1 || d_ready !== 1'b1) $display("FAIL b2b_c3 got v=%b rdy=%b want 1 1", d_rvalid, d_ready); else pass_cnt++;
    total++; if (d_rdata !== 32'hA5A5_0001) $display("FAIL b2b_c3_data got %h want a5a50001", d_rdata); else pass_cnt++;
    next(); d_req = 1'b0; #3;
    total++; if (mem_addr !== 32'h0010_0014 || d_rvalid !== 1'b0) $display("FAIL b2b_c4 got addr=%h v=%b want 00100014 0", mem_addr, d_rvalid); else pass_cnt++;
    next(); mem_rd = 32'hA5A5_0002;
    next(); mem_rd = '0; #3;
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA5A5_0002) $display("FAIL b2b_c6 got v=%b d=%h want 1 a5a50002", d_rvalid, d_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    next(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020; #3;
    total++; if (d_ready !== 1'b1) $display("FAIL rmid_c0 got %b want 1", d_ready); else pass_cnt++;
    next(); mem_rd = 32'hCAFE_0000; rstn = 1'b0; #3;
    total++; if (busy !== 1'b0 || mem_we !== 1'b0) $display("FAIL rmid_busy got busy=%b we=%b want 0 0", busy, mem_we); else pass_cnt++;
    total++; if (d_ready !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL rmid_hs got rdy=%b v=%b want 0 0", d_ready, d_rvalid); else pass_cnt++;
    total++; if (mem_addr !== 32'h0 || d_rdata !== 32'h0) $display("FAIL rmid_regs got addr=%h d=%h want 0 0", mem_addr, d_rdata); else pass_cnt++;
    next(); d_req = 1'b0;
    next(); rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next(); #3;
      total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_post%0d got dv=%b iv=%b busy=%b want 0 0 0", c, d_rvalid, if_rvalid, busy); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
